// File: rtl/lcd_char_writer_if.sv
// Valid/ready command stream between the LCD command FIFO read port and the
// character writer.
interface lcd_char_writer_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// Pops 10-bit command words and drives an HD44780 LCD in 4-bit mode:
// RS/D setup, E strobe, E-low hold per nibble, then the command's execution wait.
module lcd_char_writer #(
    parameter int T_AS        = 2,
    parameter int T_PW        = 13,
    parameter int T_H         = 27,
    parameter int T_EXEC      = 1000,
    parameter int T_EXEC_LONG = 41040,
    parameter int T_EXEC_INIT = 110700
) (
    input  logic                     clk,
    input  logic                     rst,
    lcd_char_writer_if.slave         in_if,
    output logic                     lcd_rs,
    output logic                     lcd_rw,
    output logic                     lcd_e,
    output logic [3:0]               lcd_d,
    output logic                     busy
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_AS, T_PW), max2(T_H, T_EXEC)),
                                max2(T_EXEC_LONG, T_EXEC_INIT));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       word_q, word_d;
    logic             phase_lo_q, phase_lo_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic [3:0]       lcd_d_q, lcd_d_d;
    logic             cnt_done;

    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    function automatic logic [CNT_W-1:0] exec_load(input logic [9:0] word);
        if (word[9])
            return cnt_load(T_EXEC_INIT);
        else if (!word[8] && (word[7:2] == 6'd0) && (word[1:0] != 2'd0))
            return cnt_load(T_EXEC_LONG);
        else
            return cnt_load(T_EXEC);
    endfunction

    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        phase_lo_d = phase_lo_q;
        lcd_rs_d   = lcd_rs_q;
        lcd_d_d    = lcd_d_q;

        case (state_q)
            S_IDLE: begin
                if (in_if.in_valid) begin
                    word_d     = in_if.in_data;
                    lcd_rs_d   = in_if.in_data[8];
                    lcd_d_d    = in_if.in_data[7:4];
                    phase_lo_d = 1'b0;
                    cnt_d      = cnt_load(T_AS);
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_done) begin
                    cnt_d   = cnt_load(T_PW);
                    state_d = S_EN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_EN: begin
                if (cnt_done) begin
                    cnt_d   = cnt_load(T_H);
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_done) begin
                    if (!phase_lo_q && !word_q[9]) begin
                        lcd_d_d    = word_q[3:0];
                        phase_lo_d = 1'b1;
                        cnt_d      = cnt_load(T_AS);
                        state_d    = S_SETUP;
                    end else begin
                        cnt_d   = exec_load(word_q);
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (cnt_done) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // E is a registered decode of the next state, so it cannot glitch.
        lcd_e_d = (state_d == S_EN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_q     <= '0;
            phase_lo_q <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_d_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            phase_lo_q <= phase_lo_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_e_q    <= lcd_e_d;
            lcd_d_q    <= lcd_d_d;
        end
    end

    assign in_if.in_ready = (state_q == S_IDLE);
    assign busy           = ~in_if.in_ready;
    assign lcd_rs         = lcd_rs_q;
    assign lcd_rw         = 1'b0;
    assign lcd_e          = lcd_e_q;
    assign lcd_d          = lcd_d_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Bench for lcd_char_writer: directed and random command words checked
// cycle by cycle against an arithmetic model of the LCD bus waveform.
module tb_lcd_char_writer;

    localparam int T_AS        = 2;
    localparam int T_PW        = 13;
    localparam int T_H         = 27;
    localparam int T_EXEC      = 100;
    localparam int T_EXEC_LONG = 400;
    localparam int T_EXEC_INIT = 700;
    localparam int P           = T_AS + T_PW + T_H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rs, lcd_rw, lcd_e, busy;
    logic [3:0] lcd_d;

    int n_vec = 0;
    int n_bad = 0;

    lcd_char_writer_if bus ();

    lcd_char_writer #(
        .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
        .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG), .T_EXEC_INIT(T_EXEC_INIT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_if(bus.slave),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw),
        .lcd_e(lcd_e),
        .lcd_d(lcd_d),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #(400000 * 10);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic int exec_n(input logic [9:0] w);
        if (w[9]) return T_EXEC_INIT;
        if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 || w[7:0] == 8'h03))
            return T_EXEC_LONG;
        return T_EXEC;
    endfunction

    function automatic int latency(input logic [9:0] w);
        return (w[9] ? 1 : 2) * P + exec_n(w);
    endfunction

    // Expected {in_ready, busy, rw, e, rs, d} i cycles after the transfer edge.
    function automatic logic [8:0] expect_bus(input logic [9:0] w, input int i);
        int         nn;
        int         k;
        int         off;
        logic [3:0] nib;
        logic       e;
        logic       rdy;
        nn = w[9] ? 1 : 2;
        e  = 1'b0;
        if (i < nn * P) begin
            k   = i / P;
            off = i % P;
            nib = (k == 0) ? w[7:4] : w[3:0];
            e   = (off >= T_AS) && (off < T_AS + T_PW);
        end else begin
            nib = (nn == 1) ? w[7:4] : w[3:0];
        end
        rdy = (i >= latency(w));
        return {rdy, ~rdy, 1'b0, e, w[8], nib};
    endfunction

    function automatic logic [8:0] observe();
        return {bus.in_ready, busy, lcd_rw, lcd_e, lcd_rs, lcd_d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered at a negedge with in_valid=1 and in_data=w presented to an idle DUT.
    task automatic run_word(input logic [9:0] w, input bit next_valid,
                            input logic [9:0] next_w, input string tag);
        int         lat;
        int         rdy_at;
        bit         miss;
        logic [8:0] obs, exp, fo, fe;
        lat    = latency(w);
        rdy_at = -1;
        miss   = 1'b0;
        fo     = '0;
        fe     = '0;
        check({tag, "_ready_pre"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = next_valid;
        bus.in_data  = next_valid ? next_w : 10'($urandom);
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            obs = observe();
            exp = expect_bus(w, i);
            if (!miss) begin
                fo = obs;
                fe = exp;
                if (obs !== exp) miss = 1'b1;
            end
            if (bus.in_ready && rdy_at < 0) rdy_at = i;
            if (!next_valid && (i % 7 == 3)) bus.in_data = 10'($urandom);
        end
        check({tag, "_latency"}, 32'(rdy_at), 32'(lat));
        check({tag, "_bus"}, 32'(fo), 32'(fe));
    endtask

    task automatic send(input logic [9:0] w, input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        run_word(w, 1'b0, 10'd0, tag);
    endtask

    function automatic logic [9:0] gen_word();
        case ($urandom_range(0, 3))
            0:       return 10'($urandom);
            1:       return {2'b00, 8'($urandom_range(0, 4))};
            2:       return {1'b1, 1'($urandom), 8'($urandom)};
            default: return {1'b0, 1'($urandom), 8'($urandom)};
        endcase
    endfunction

    initial begin
        int         viol;
        logic [9:0] cur, nxt;
        bit         b2b;

        bus.in_valid = 1'b1;
        bus.in_data  = 10'h3FF;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(observe()), 32'h100);

        // Quiet idle: no strobes and always ready while in_valid is low.
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        viol = 0;
        for (int i = 0; i < 2000; i++) begin
            bus.in_data = 10'($urandom);
            @(negedge clk);
            if (!bus.in_ready || lcd_e || busy) viol++;
        end
        check("idle_quiet", 32'(viol), 32'd0);

        send(10'h141, "char_A");
        send(10'h001, "clear");
        send(10'h004, "entry");
        send(10'h003, "home3");
        send(10'h101, "data_01");
        send(10'h230, "nibble_3");
        send(10'h000, "cmd_00");
        send(10'h002, "home2");
        send(10'h203, "nibble_long_byte");

        bus.in_valid = 1'b1;
        bus.in_data  = 10'h028;
        run_word(10'h028, 1'b1, 10'h00C, "b2b_0");
        run_word(10'h00C, 1'b1, 10'h148, "b2b_1");
        run_word(10'h148, 1'b0, 10'h000, "b2b_2");

        // Abort during the first strobe; nothing of the word may survive.
        bus.in_valid = 1'b1;
        bus.in_data  = 10'h141;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10 && !lcd_e; i++) @(negedge clk);
        check("abort_e_high", 32'(lcd_e), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_reset_outputs", 32'(observe()), 32'h100);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        viol = 0;
        for (int i = 0; i < 3 * P; i++) begin
            @(negedge clk);
            if (!bus.in_ready || lcd_e || lcd_d != 4'd0 || lcd_rs) viol++;
        end
        check("abort_no_residue", 32'(viol), 32'd0);
        send(10'h141, "char_A_after_rst");

        cur = gen_word();
        bus.in_valid = 1'b1;
        bus.in_data  = cur;
        for (int k = 0; k < 25; k++) begin
            nxt = gen_word();
            b2b = 1'($urandom);
            run_word(cur, b2b, nxt, $sformatf("rand%0d", k));
            if (!b2b) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = nxt;
            end
            cur = nxt;
        end
        run_word(cur, 1'b0, 10'd0, "rand_last");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
